serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer that time-shares one gate-level full-adder cell (xor/and/or: sum = a^b^cIN, carry = a&b | cIN&(a^b)) to add two W-bit operands plus carry-in.
- Processes one bit per clock, LSB first. Uses a start/busy/done handshake.
- Sits between a requesting controller and the shared full-adder cell. It captures operands, sequences the cell W times and publishes the registered sum and carry-out.

---
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two W-bit operands and a carry-in,
// then steps one shared full-adder cell LSB-first for W clocks and publishes
// the registered sum and carry-out with a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cIN,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         cOUT
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    ra_q, ra_d;
  logic [W-1:0]    rb_q, rb_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    psum_q, psum_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    z_q, z_d;
  logic            cout_q, cout_d;

  // Shared full-adder cell, fed from the operand LSBs and the running carry.
  logic fa_a, fa_b, fa_sum, fa_carry;
  assign fa_a     = ra_q[0];
  assign fa_b     = rb_q[0];
  assign fa_sum   = fa_a ^ fa_b ^ carry_q;
  assign fa_carry = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      count_q <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      count_q <= count_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and datapath sequencing for IDLE / RUN / DONE.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    carry_d = carry_q;
    psum_d  = psum_q;
    count_d = count_q;
    z_d     = z_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = cIN;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Shift then set the MSB so the W=1 case needs no special slicing.
        psum_d        = psum_q >> 1;
        psum_d[W-1]   = fa_sum;
        ra_d          = ra_q >> 1;
        rb_d          = rb_q >> 1;
        carry_d       = fa_carry;
        count_d       = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
          z_d     = psum_d;
          cout_d  = fa_carry;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign z    = z_q;
  assign cOUT = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (W=4 main instance, W=1 boundary instance).
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a, b;
  logic       cIN;
  logic       busy, done;
  logic [3:0] z;
  logic       cOUT;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cIN1;
  logic       busy1, done1;
  logic [0:0] z1;
  logic       cOUT1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cIN(cIN),
    .busy(busy), .done(done), .z(z), .cOUT(cOUT)
  );

  serial_add_ctrl #(.W(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cIN(cIN1),
    .busy(busy1), .done(done1), .z(z1), .cOUT(cOUT1)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the given operands and wait (bounded) for done.
  task automatic do_op(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                       output logic timed_out);
    a = va; b = vb; cIN = vc; start = 1'b1;
    tick();
    start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = 4'($urandom); b = 4'($urandom); cIN = 1'($urandom); start = 1'($urandom);
      tick();
    end
    total++;
    if ({busy, done, z, cOUT} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b z=%b cOUT=%b, want all 0", busy, done, z, cOUT);
    end
    total++;
    if ({busy1, done1, z1, cOUT1} !== 4'b0) begin
      bad++;
      $display("FAIL reset_outputs_w1: got busy=%b done=%b z=%b cOUT=%b, want all 0", busy1, done1, z1, cOUT1);
    end
    start = 1'b0;
    reset = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_run: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    a = 4'b0101; b = 4'b0011; cIN = 1'b0; start = 1'b1;
    tick(); // E0
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || z !== 4'b0000) begin
        bad++;
        $display("FAIL basic_run[%0d]: busy=%b done=%b z=%b, want 1 0 0000", k, busy, done, z);
      end
      if (k < 3) tick();
    end
    tick(); // E4
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || z !== 4'b1000 || cOUT !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: done=%b busy=%b z=%b cOUT=%b, want 1 0 1000 0", done, busy, z, cOUT);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || z !== 4'b1000) begin
      bad++;
      $display("FAIL basic_after: done=%b busy=%b z=%b, want 0 0 1000", done, busy, z);
    end
  endtask

  task automatic test_overflow();
    a = 4'b1111; b = 4'b1111; cIN = 1'b1; start = 1'b1;
    tick(); // E0
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      // operands scrambled after capture must not matter
      a = 4'(k * 3); b = 4'(k + 9); cIN = 1'(k);
      total++;
      if (z !== 4'b1000 || cOUT !== 1'b0) begin
        bad++;
        $display("FAIL overflow_hold[%0d]: z=%b cOUT=%b, want 1000 0", k, z, cOUT);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || z !== 4'b1111 || cOUT !== 1'b1) begin
      bad++;
      $display("FAIL overflow_result: done=%b z=%b cOUT=%b, want 1 1111 1", done, z, cOUT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_busy, exp_done;
    start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        a = 4'd3; b = 4'd5; cIN = 1'b0;
      end else if (k == 6) begin
        a = 4'd9; b = 4'd6; cIN = 1'b1;
      end else begin
        a = ~a; b = b ^ 4'b1010; cIN = ~cIN;
      end
      tick(); // edge Ek
      exp_busy = (k <= 3) || (k >= 6 && k <= 9);
      exp_done = (k == 4) || (k == 10);
      total++;
      if (busy !== exp_busy || done !== exp_done) begin
        bad++;
        $display("FAIL b2b_hs[%0d]: busy=%b done=%b, want %b %b", k, busy, done, exp_busy, exp_done);
      end
      if (k == 4) begin
        total++;
        if (z !== 4'd8 || cOUT !== 1'b0) begin
          bad++;
          $display("FAIL b2b_first: z=%b cOUT=%b, want 1000 0", z, cOUT);
        end
      end
      if (k == 10) begin
        total++;
        if (z !== 4'd0 || cOUT !== 1'b1) begin
          bad++;
          $display("FAIL b2b_second: z=%b cOUT=%b, want 0000 1", z, cOUT);
        end
      end
    end
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_exhaustive();
    logic       to;
    logic [4:0] expv;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          do_op(4'(ia), 4'(ib), 1'(ic), to);
          expv = 5'(ia) + 5'(ib) + 5'(ic);
          total++;
          if (to) begin
            bad++;
            $display("FAIL exh_timeout a=%0d b=%0d c=%0d: no done within 20 cycles", ia, ib, ic);
          end else if (z !== expv[3:0] || cOUT !== expv[4]) begin
            bad++;
            $display("FAIL exh a=%0d b=%0d c=%0d: got cOUT=%b z=%b, want %b %b",
                     ia, ib, ic, cOUT, z, expv[4], expv[3:0]);
          end
          tick();
        end
      end
    end
  endtask

  task automatic test_midop_reset();
    logic to;
    a = 4'd7; b = 4'd7; cIN = 1'b0; start = 1'b1;
    tick(); // E0
    start = 1'b0;
    tick(); // E1
    reset = 1'b1;
    tick(); // E2 with reset
    reset = 1'b0;
    total++;
    if ({busy, done, z, cOUT} !== 7'b0) begin
      bad++;
      $display("FAIL midop_reset: busy=%b done=%b z=%b cOUT=%b, want all 0", busy, done, z, cOUT);
    end
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midop_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    do_op(4'b0001, 4'b0001, 1'b1, to);
    total++;
    if (to || z !== 4'b0011 || cOUT !== 1'b0) begin
      bad++;
      $display("FAIL midop_next: timeout=%b z=%b cOUT=%b, want 0 0011 0", to, z, cOUT);
    end
    tick();
  endtask

  task automatic test_w1();
    a1 = 1'b1; b1 = 1'b1; cIN1 = 1'b1; start1 = 1'b1;
    tick(); // E0
    start1 = 1'b0;
    total++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL w1_run: busy=%b done=%b, want 1 0", busy1, done1);
    end
    tick(); // E1
    total++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || z1 !== 1'b1 || cOUT1 !== 1'b1) begin
      bad++;
      $display("FAIL w1_result: done=%b busy=%b z=%b cOUT=%b, want 1 0 1 1", done1, busy1, z1, cOUT1);
    end
    a1 = 1'b1; b1 = 1'b0; cIN1 = 1'b0; start1 = 1'b1;
    tick(); // DONE -> IDLE, start ignored
    tick(); // accept
    start1 = 1'b0;
    tick();
    total++;
    if (done1 !== 1'b1 || z1 !== 1'b1 || cOUT1 !== 1'b0) begin
      bad++;
      $display("FAIL w1_second: done=%b z=%b cOUT=%b, want 1 1 0", done1, z1, cOUT1);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cIN = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cIN1 = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_w1();
    test_exhaustive();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
